// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller in front of mem_read / mem_write.
// Takes one request at a time from execute, drives the read or write block
// until it completes (or times out), then returns one response to writeback.
//
// Ports:
//   ACLK, ARESETn                 clock (rising edge), async active-low reset
//   in_valid/in_ready             request handshake
//   in_ren/in_wen                 load / store select
//   in_addr, in_wdata             byte address, right-justified store data
//   in_size, in_unsigned          access size (1/2/4/8 B), load zero-extend
//   rd_en/rd_addr/rd_valid/rd_data       mem_read interface
//   wr_en/wr_addr/wr_data/wr_mask/wr_finish  mem_write interface
//   out_valid/out_ready           response handshake
//   out_rdata, out_err            extended load data, error flag
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_ren,
  input  logic        in_wen,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  output logic        rd_en,
  output logic [63:0] rd_addr,
  input  logic        rd_valid,
  input  logic [63:0] rd_data,
  output logic        wr_en,
  output logic [63:0] wr_addr,
  output logic [63:0] wr_data,
  output logic [3:0]  wr_mask,
  input  logic        wr_finish,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          misaligned;
  logic          timeout_hit;
  logic [63:0]   shifted;
  logic [63:0]   load_ext;
  logic [63:0]   store_data;

  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = in_addr[0];
      2'd2: misaligned = |in_addr[1:0];
      default: misaligned = |in_addr[2:0];
    endcase
  end

  // rd_data is the whole aligned doubleword; bring the addressed byte to bit 0.
  assign shifted     = rd_data >> {addr_q[2:0], 3'b000};
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    load_ext = '0;
    case (size_q)
      2'd0: load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    store_data = '0;
    case (size_q)
      2'd0: store_data = {56'd0, wdata_q[7:0]};
      2'd1: store_data = {48'd0, wdata_q[15:0]};
      2'd2: store_data = {32'd0, wdata_q[31:0]};
      default: store_data = wdata_q;
    endcase
  end

  // Next state and registered datapath.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          addr_d  = in_addr;
          wdata_d = in_wdata;
          size_d  = in_size;
          uns_d   = in_unsigned;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          if ((in_ren && in_wen) || ((in_ren || in_wen) && misaligned)) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (in_ren) begin
            state_d = S_READ;
          end else if (in_wen) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_READ: begin
        // Completion wins over a timeout landing in the same cycle.
        if (rd_valid) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wr_finish) begin
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are pure state decodes so reset drops en immediately.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    rd_en     = (state_q == S_READ);
    wr_en     = (state_q == S_WRITE);
    out_valid = (state_q == S_RESP);
    rd_addr   = rd_en ? addr_q : '0;
    wr_addr   = wr_en ? addr_q : '0;
    wr_data   = wr_en ? store_data : '0;
    wr_mask   = wr_en ? (4'b0001 << size_q) : 4'b0000;
    out_rdata = out_valid ? rdata_q : '0;
    out_err   = out_valid & err_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a transaction-level reference model.
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        ACLK, ARESETn;
  logic        in_valid, in_ready, in_ren, in_wen, in_unsigned;
  logic [63:0] in_addr, in_wdata;
  logic [1:0]  in_size;
  logic        rd_en, rd_valid, wr_en, wr_finish;
  logic [63:0] rd_addr, rd_data, wr_addr, wr_data;
  logic [3:0]  wr_mask;
  logic        out_valid, out_ready, out_err;
  logic [63:0] out_rdata;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size), .in_unsigned(in_unsigned),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_finish(wr_finish),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory block models: mem_read shows valid=1 whenever it is not enabled.
  int rd_lat = 0, wr_lat = 0;
  int rd_age = 0, wr_age = 0;
  always @(posedge ACLK) rd_age <= rd_en ? rd_age + 1 : 0;
  always @(posedge ACLK) wr_age <= wr_en ? wr_age + 1 : 0;
  assign rd_valid  = !rd_en ? 1'b1 : (rd_lat >= 0 && rd_age == rd_lat);
  assign wr_finish = wr_en && (wr_lat >= 0) && (wr_age == wr_lat);

  // Current transaction expectations.
  logic [63:0] cur_addr, exp_wdata, exp_mask, exp_rdata;
  logic        exp_err;
  int          en_total = 0;
  logic [63:0] last_rdata;
  logic        last_err;

  function automatic logic [63:0] ld_model(input logic [63:0] dw, input logic [63:0] addr,
                                            input logic [1:0] size, input bit uns);
    int nb;
    logic [63:0] m, v;
    nb = 8 << size;
    m  = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v  = (dw >> (8 * (addr % 8))) & m;
    if (!uns && v[nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [63:0] st_model(input logic [63:0] wd, input logic [1:0] size);
    int nb;
    nb = 8 << size;
    return (nb == 64) ? wd : (wd & ((64'd1 << nb) - 64'd1));
  endfunction

  // Per-cycle compare against the current expectations.
  initial forever begin
    @(negedge ACLK);
    chk("en_exclusive", {63'd0, rd_en && wr_en}, 64'd0);
    chk("in_ready_busy", {63'd0, in_ready}, {63'd0, !(rd_en || wr_en || out_valid)});
    if (rd_en) begin
      en_total++;
      chk("rd_addr", rd_addr, cur_addr);
    end else chk("rd_addr_idle", rd_addr, 64'd0);
    if (wr_en) begin
      en_total++;
      chk("wr_addr", wr_addr, cur_addr);
      chk("wr_data", wr_data, exp_wdata);
      chk("wr_mask", {60'd0, wr_mask}, exp_mask);
    end else chk("wr_addr_idle", wr_addr, 64'd0);
    if (out_valid) begin
      chk("out_rdata", out_rdata, exp_rdata);
      chk("out_err", {63'd0, out_err}, {63'd0, exp_err});
    end
  end

  int exp_en, exp_lat;

  // Compute expectations from the request and drive it (called just after an edge).
  task automatic setup(input bit ren, input bit wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] dw,
                       input logic [1:0] size, input bit uns, input int lat);
    int  nbytes;
    bit  mis, err, mem, tmo;
    nbytes = 1 << size;
    mis = (addr % nbytes) != 0;
    err = (ren && wen) || ((ren || wen) && mis);
    mem = (ren || wen) && !err;
    tmo = mem && (lat < 0 || lat >= TO);
    exp_err   = err || tmo;
    exp_rdata = (ren && mem && !tmo) ? ld_model(dw, addr, size, uns) : 64'd0;
    exp_wdata = st_model(wdata, size);
    exp_mask  = 64'd1 << size;
    cur_addr  = addr;
    exp_en    = !mem ? 0 : (tmo ? TO : lat + 1);
    exp_lat   = mem ? exp_en + 1 : 1;
    rd_data = dw;
    rd_lat  = lat;
    wr_lat  = lat;
    in_ren = ren; in_wen = wen; in_addr = addr; in_wdata = wdata;
    in_size = size; in_unsigned = uns;
    in_valid = 1'b1;
  endtask

  task automatic run_txn(input bit ren, input bit wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] dw,
                         input logic [1:0] size, input bit uns, input int lat, input int hold);
    int k, en0;
    setup(ren, wen, addr, wdata, dw, size, uns, lat);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    en0 = en_total;
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 64) begin
      @(posedge ACLK); #1;
      k++;
    end
    chk("resp_seen", {63'd0, out_valid}, 64'd1);
    chk("resp_latency", 64'(k), 64'(exp_lat));
    // Offer another request while the response is pending; it must not be taken.
    in_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      chk("resp_held", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    last_rdata = out_rdata;
    last_err   = out_err;
    chk("en_cycles", 64'(en_total - en0), 64'(exp_en));
    out_ready = 1'b1;
    @(posedge ACLK); #1;
    out_ready = 1'b0;
    chk("resp_done", {63'd0, out_valid}, 64'd0);
    chk("back_idle", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    in_valid = 0; in_ren = 0; in_wen = 0; in_addr = '0; in_wdata = '0;
    in_size = 0; in_unsigned = 0; out_ready = 0; rd_data = '0;
    cur_addr = '0; exp_wdata = '0; exp_mask = '0; exp_rdata = '0; exp_err = 0;
    @(posedge ACLK); #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_rd_en", {63'd0, rd_en}, 64'd0);
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;

    // Load byte signed / unsigned.
    run_txn(1, 0, 64'h80000003, 64'd0, 64'h00000000_AB000000, 2'd0, 0, 0, 0);
    chk("lb_lit", last_rdata, 64'hFFFFFFFFFFFFFFAB);
    chk("lb_err_lit", {63'd0, last_err}, 64'd0);
    run_txn(1, 0, 64'h80000003, 64'd0, 64'h00000000_AB000000, 2'd0, 1, 1, 0);
    chk("lbu_lit", last_rdata, 64'h00000000000000AB);
    // Store word.
    run_txn(0, 1, 64'h80000008, 64'h1122334455667788, 64'd0, 2'd2, 0, 2, 2);
    chk("sw_rdata_lit", last_rdata, 64'd0);
    chk("sw_err_lit", {63'd0, last_err}, 64'd0);
    // Misaligned halfword load.
    run_txn(1, 0, 64'h80000001, 64'd0, 64'hFFFF, 2'd1, 0, 0, 0);
    chk("lh_mis_lit", {63'd0, last_err}, 64'd1);
    // Timeout with response back-pressure.
    run_txn(1, 0, 64'h80000010, 64'd0, 64'h1234, 2'd3, 0, -1, 3);
    chk("tmo_err_lit", {63'd0, last_err}, 64'd1);
    chk("tmo_rdata_lit", last_rdata, 64'd0);
    // Other sizes and corner requests.
    run_txn(1, 0, 64'h80000006, 64'd0, 64'h8001222233334444, 2'd1, 0, 0, 1);
    chk("lh_sext_lit", last_rdata, 64'hFFFFFFFFFFFF8001);
    run_txn(1, 0, 64'h80000004, 64'd0, 64'hDEADBEEF00000000, 2'd2, 1, 2, 0);
    chk("lwu_lit", last_rdata, 64'h00000000DEADBEEF);
    run_txn(1, 0, 64'h80000010, 64'd0, 64'h0123456789ABCDEF, 2'd3, 0, 0, 0);
    chk("ld_lit", last_rdata, 64'h0123456789ABCDEF);
    run_txn(0, 1, 64'h80000018, 64'hCAFEF00DDEADBEEF, 64'd0, 2'd3, 0, 0, 0);
    run_txn(0, 1, 64'h80000005, 64'hFFFFFFFFFFFFFF5A, 64'd0, 2'd0, 0, 1, 0);
    run_txn(0, 1, 64'h80000020, 64'h55, 64'd0, 2'd0, 0, -1, 0);
    chk("st_tmo_lit", {63'd0, last_err}, 64'd1);
    run_txn(1, 1, 64'h80000000, 64'd0, 64'd0, 2'd0, 0, 0, 0);
    chk("both_err_lit", {63'd0, last_err}, 64'd1);
    run_txn(0, 0, 64'h80000000, 64'd0, 64'hFF, 2'd0, 0, 0, 0);
    chk("none_err_lit", {63'd0, last_err}, 64'd0);
    run_txn(0, 1, 64'h80000002, 64'd0, 64'd0, 2'd2, 0, 0, 0);
    run_txn(1, 0, 64'h80000004, 64'd0, 64'd0, 2'd3, 0, 0, 0);

    // Reset in the middle of a store.
    setup(0, 1, 64'h80000040, 64'h99, 64'd0, 2'd0, 0, -1);
    @(posedge ACLK); #1;
    in_valid = 1'b0;
    @(posedge ACLK); #1;
    chk("mid_wr_en", {63'd0, wr_en}, 64'd1);
    @(posedge ACLK); #3;
    ARESETn = 1'b0;
    #1;
    chk("rst_drop_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_drop_wr_addr", wr_addr, 64'd0);
    chk("rst_in_ready2", {63'd0, in_ready}, 64'd1);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    run_txn(1, 0, 64'h80000042, 64'd0, 64'h0000_0000_0080_0000, 2'd0, 0, 1, 0);
    chk("post_rst_lb_lit", last_rdata, 64'hFFFFFFFFFFFFFF80);

    repeat (2) @(posedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit controller sitting directly upstream of mem_read and mem_write.
- Accepts one memory request at a time from the execute stage and drives the en/addr/wdata/wmask interfaces of the read and write blocks, holding each request until that block completes.
- Aligns and sign- or zero-extends load data, then returns a single response to the writeback stage through a valid/ready handshake.
- Detects misaligned or illegal requests and memory timeouts.

Parameters:
- TIMEOUT, 256, maximum number of wait cycles in READ/WRITE before an error response is forced; 0 disables the timeout.

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_ren  in  1  load request
- in_wen  in  1  store request
- in_addr  in  64  byte address
- in_wdata  in  64  store data, right-justified
- in_size  in  2  0=1B, 1=2B, 2=4B, 3=8B
- in_unsigned  in  1  zero-extend load when 1, sign-extend when 0
- rd_en  out  1  to mem_read en
- rd_addr  out  64  to mem_read addr
- rd_valid  in  1  from mem_read valid
- rd_data  in  64  from mem_read rdata: the 8-byte-aligned doubleword containing rd_addr
- wr_en  out  1  to mem_write en
- wr_addr  out  64  to mem_write addr
- wr_data  out  64  to mem_write wdata, right-justified
- wr_mask  out  4  one-hot size: 0001=1B, 0010=2B, 0100=4B, 1000=8B
- wr_finish  in  1  from mem_write finish
- out_valid  out  1  response valid
- out_ready  in  1  response consumed when out_valid&&out_ready
- out_rdata  out  64  extended load data; 0 for stores and errors
- out_err  out  1  misaligned, illegal or timeout

Behaviour:
- Reset (ARESETn low, asynchronous): FSM=IDLE; all outputs and internal registers 0, except in_ready, which follows the state decode (1 in IDLE).
- Reset asserted mid-operation aborts the transaction immediately: rd_en and wr_en drop without waiting for completion.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - in_ready=1; on acceptance, latch addr, wdata, size and unsigned.
  - in_ren&&!in_wen and aligned -> READ.
  - in_wen&&!in_ren and aligned -> WRITE.
  - Misaligned (addr mod 2^size != 0) or both ren and wen set -> RESP with err=1.
  - Neither ren nor wen set -> RESP with err=0, rdata=0.
- READ:
  - rd_en=1; rd_addr holds the latched addr.
  - rd_valid is sampled only while rd_en=1, because mem_read reports valid=1 whenever en=0.
  - On rd_valid=1: out_rdata <= extend(rd_data >> (addr[2:0]*8), size, unsigned), then -> RESP.
- WRITE:
  - wr_en=1; wr_addr, wr_data and wr_mask held constant.
  - wr_data = latched wdata with bytes above the access size zeroed.
  - On wr_finish=1 -> RESP with err=0.
  - wr_en drops in the cycle after wr_finish is sampled.
- Timeout:
  - Wait counter is cleared on entry to READ or WRITE and increments each cycle without completion.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 -> RESP with err=1, rdata=0; en is deasserted.
- RESP: out_valid=1 and outputs held stable until out_ready=1, then -> IDLE. No new request is accepted in the same cycle.
- Latency: request accepted at edge T -> rd_en/wr_en high in cycle T+1. An immediate completion in cycle T+1 gives out_valid in cycle T+2. Error requests give out_valid in cycle T+1.
- in_ready=0 in every state except IDLE.
- rd_en and wr_en are never high together.
- rd_addr and wr_addr are 0 when the corresponding en=0.

Test Plan:
- Load byte, addr=0x80000003, size=0, unsigned=0, rd_data=0x00000000_AB000000 -> out_rdata=0xFFFFFFFFFFFFFFAB, err=0.
- Same load with unsigned=1 -> out_rdata=0x00000000000000AB.
- Store word, addr=0x80000008, wdata=0x1122334455667788, size=2 -> wr_en high with wr_data=0x0000000055667788 and wr_mask=0100 until wr_finish; response out_rdata=0, err=0.
- Load halfword at addr=0x80000001 -> no rd_en or wr_en pulse; out_valid in cycle T+1 with err=1.
- TIMEOUT=4, load with rd_valid held 0 -> rd_en high for exactly 4 cycles, then err=1. Also hold out_ready=0 for 3 cycles -> response stays stable and in_ready=0.
- Drop ARESETn during WRITE -> wr_en=0 immediately; after release, in_ready=1 and the next load completes normally.
